// File: rtl/fibo_ctrl_pkg.sv
// Shared types and constants for the Fibonacci sequencing controller.
// Holds the FSM state encoding, error codes and the error/overflow result patterns.
package fibo_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK,
    ST_B2B,
    ST_FIB,
    ST_B2D,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BCD     = 2'd1,
    ERR_OVF     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  localparam logic [15:0] ERR_PATTERN = 16'hEEEE;
  localparam logic [15:0] OVF_PATTERN = 16'h9999;

  // True when both nibbles are legal decimal digits.
  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/stage_timer.sv
// Per-stage watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the stage has used up its LIMIT-cycle budget.
module stage_timer #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_count;

  // Count saturates on the last cycle so a stalled FSM never wraps the timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/fibo_seq_ctrl.sv
// Sequences BCD index -> binary -> Fibonacci -> BCD result through three external
// units, with input validation, overflow detection and a per-stage watchdog.
module fibo_seq_ctrl
  import fibo_ctrl_pkg::*;
#(
  parameter int MAX_N       = 20,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bcd_in,
  output logic        b2b_start,
  output logic [7:0]  b2b_bcd,
  input  logic        b2b_done,
  input  logic [6:0]  b2b_bin,
  output logic        fib_start,
  output logic [4:0]  fib_n,
  input  logic        fib_done,
  input  logic [13:0] fib_f,
  output logic        bcd_start,
  output logic [13:0] bcd_bin,
  input  logic        bcd_done,
  input  logic [15:0] bcd_bcd,
  output logic [15:0] result_bcd,
  output logic        result_valid,
  output logic        done,
  output logic        busy,
  output logic [1:0]  err
);

  state_e      r_state, w_next;
  logic [7:0]  r_bcd;
  logic [4:0]  r_fib_n;
  logic [13:0] r_bcd_bin;
  logic [15:0] r_result;
  logic        r_valid;
  err_e        r_err;
  logic        r_b2b_start, r_fib_start, r_bcd_start;

  logic w_accept, w_chk_bad, w_b2b_ok, w_b2b_ovf, w_fib_ok, w_b2d_ok, w_timeout;
  logic w_in_stage, w_expired, w_clear;

  assign w_in_stage = (r_state == ST_B2B) || (r_state == ST_FIB) || (r_state == ST_B2D);
  assign w_clear    = (w_next != r_state);

  stage_timer #(.LIMIT(TIMEOUT_CYC)) u_stage_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .enable  (w_in_stage),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // A unit's done is checked before the watchdog so a same-cycle done wins.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_chk_bad = 1'b0;
    w_b2b_ok  = 1'b0;
    w_b2b_ovf = 1'b0;
    w_fib_ok  = 1'b0;
    w_b2d_ok  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = ST_CHK;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_CHK: begin
        if (!bcd_ok(r_bcd)) begin
          w_chk_bad = 1'b1;
          w_next    = ST_DONE;
        end else begin
          w_next = ST_B2B;
        end
      end
      ST_B2B: begin
        if (b2b_done) begin
          if (int'(b2b_bin) > MAX_N) begin
            w_b2b_ovf = 1'b1;
            w_next    = ST_DONE;
          end else begin
            w_b2b_ok = 1'b1;
            w_next   = ST_FIB;
          end
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_FIB: begin
        if (fib_done) begin
          w_fib_ok = 1'b1;
          w_next   = ST_B2D;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_B2D: begin
        if (bcd_done) begin
          w_b2d_ok = 1'b1;
          w_next   = ST_DONE;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd       <= '0;
      r_fib_n     <= '0;
      r_bcd_bin   <= '0;
      r_result    <= '0;
      r_valid     <= 1'b0;
      r_err       <= ERR_NONE;
      r_b2b_start <= 1'b0;
      r_fib_start <= 1'b0;
      r_bcd_start <= 1'b0;
    end else begin
      r_b2b_start <= (w_next == ST_B2B) && (r_state != ST_B2B);
      r_fib_start <= (w_next == ST_FIB) && (r_state != ST_FIB);
      r_bcd_start <= (w_next == ST_B2D) && (r_state != ST_B2D);
      if (w_accept) begin
        r_bcd   <= bcd_in;
        r_valid <= 1'b0;
        r_err   <= ERR_NONE;
      end
      if (w_chk_bad || w_timeout) begin
        r_err    <= w_chk_bad ? ERR_BCD : ERR_TIMEOUT;
        r_result <= ERR_PATTERN;
      end
      if (w_b2b_ovf) begin
        r_err    <= ERR_OVF;
        r_result <= OVF_PATTERN;
      end
      if (w_b2b_ok) r_fib_n   <= b2b_bin[4:0];
      if (w_fib_ok) r_bcd_bin <= fib_f;
      if (w_b2d_ok) begin
        r_result <= bcd_bcd;
        r_err    <= ERR_NONE;
      end
      if (w_next == ST_DONE) r_valid <= 1'b1;
    end
  end

  assign b2b_start    = r_b2b_start;
  assign b2b_bcd      = r_bcd;
  assign fib_start    = r_fib_start;
  assign fib_n        = r_fib_n;
  assign bcd_start    = r_bcd_start;
  assign bcd_bin      = r_bcd_bin;
  assign result_bcd   = r_result;
  assign result_valid = r_valid;
  assign done         = (r_state == ST_DONE);
  assign busy         = (r_state == ST_CHK) || w_in_stage;
  assign err          = r_err;

endmodule

// File: tb/tb_fibo_seq_ctrl.sv
// Randomized self-checking bench for fibo_seq_ctrl with behavioural unit models
// and a reference model computing expected results directly from the index.
module tb_fibo_seq_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bcd_in = 8'h00;
  logic        b2b_start;
  logic [7:0]  b2b_bcd;
  logic        b2b_done = 1'b0;
  logic [6:0]  b2b_bin = '0;
  logic        fib_start;
  logic [4:0]  fib_n;
  logic        fib_done = 1'b0;
  logic [13:0] fib_f = '0;
  logic        bcd_start;
  logic [13:0] bcd_bin;
  logic        bcd_done = 1'b0;
  logic [15:0] bcd_bcd = '0;
  logic [15:0] result_bcd;
  logic        result_valid;
  logic        done;
  logic        busy;
  logic [1:0]  err;

  fibo_seq_ctrl #(.MAX_N(20), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .b2b_start(b2b_start), .b2b_bcd(b2b_bcd), .b2b_done(b2b_done), .b2b_bin(b2b_bin),
    .fib_start(fib_start), .fib_n(fib_n), .fib_done(fib_done), .fib_f(fib_f),
    .bcd_start(bcd_start), .bcd_bin(bcd_bin), .bcd_done(bcd_done), .bcd_bcd(bcd_bcd),
    .result_bcd(result_bcd), .result_valid(result_valid), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit-model controls
  logic zero_wait = 1'b0;
  logic fib_hold  = 1'b0;
  int   fib_force = -1;

  // Monitor counters and captures (written only by the monitor)
  int          cnt_b2b = 0, cnt_fib = 0, cnt_bcd = 0, cnt_done = 0;
  int          fib_cyc = 0, done_cyc = 0;
  logic [4:0]  cap_fib_n = '0;
  logic [13:0] cap_bcd_bin = '0;

  always @(negedge clk) begin
    if (b2b_start) cnt_b2b++;
    if (fib_start) begin cnt_fib++; cap_fib_n = fib_n; fib_cyc = cyc; end
    if (bcd_start) begin cnt_bcd++; cap_bcd_bin = bcd_bin; end
    if (done) begin cnt_done++; done_cyc = cyc; end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fib_of(input int n);
    int a, b, t;
    a = 0; b = 1;
    for (int i = 0; i < n; i++) begin t = a + b; a = b; b = t; end
    return a;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0; x = v;
    for (int i = 0; i < 4; i++) begin r[i*4 +: 4] = 4'(x % 10); x = x / 10; end
    return r;
  endfunction

  // stages: 0 = rejected in CHK, 1 = overflow after B2B, 3 = full pipeline
  task automatic ref_model(input logic [7:0] bcd, output logic [15:0] res,
                           output logic [1:0] e, output int stages, output int n);
    n = 0;
    if (bcd[7:4] > 4'd9 || bcd[3:0] > 4'd9) begin
      res = 16'hEEEE; e = 2'd1; stages = 0;
    end else begin
      n = int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
      if (n > 20) begin res = 16'h9999; e = 2'd2; stages = 1; end
      else begin res = to_bcd(fib_of(n)); e = 2'd0; stages = 3; end
    end
  endtask

  // Unit models: respond to each start pulse after 0..3 cycles
  initial begin : resp_b2b
    int d, v;
    forever begin
      @(posedge clk); #1;
      if (b2b_start) begin
        v = int'(b2b_bcd[7:4]) * 10 + int'(b2b_bcd[3:0]);
        d = zero_wait ? 0 : int'($urandom_range(0, 3));
        repeat (d) begin @(posedge clk); #1; end
        b2b_bin = 7'(v); b2b_done = 1'b1;
        @(posedge clk); #1; b2b_done = 1'b0;
      end
    end
  end

  initial begin : resp_fib
    int d;
    logic [4:0] n;
    forever begin
      @(posedge clk); #1;
      if (fib_start) begin
        n = fib_n;
        if (fib_hold) d = 20;
        else if (fib_force >= 0) d = fib_force;
        else if (zero_wait) d = 0;
        else d = int'($urandom_range(0, 3));
        repeat (d) begin @(posedge clk); #1; end
        fib_f = 14'(fib_of(int'(n))); fib_done = 1'b1;
        @(posedge clk); #1; fib_done = 1'b0;
      end
    end
  end

  initial begin : resp_bcd
    int d;
    logic [13:0] b;
    forever begin
      @(posedge clk); #1;
      if (bcd_start) begin
        b = bcd_bin;
        d = zero_wait ? 0 : int'($urandom_range(0, 3));
        repeat (d) begin @(posedge clk); #1; end
        bcd_bcd = to_bcd(int'(b)); bcd_done = 1'b1;
        @(posedge clk); #1; bcd_done = 1'b0;
      end
    end
  end

  task automatic pulse_start(input logic [7:0] bcd, output int c_start);
    @(posedge clk); #1;
    start = 1'b1; bcd_in = bcd; c_start = cyc;
    @(posedge clk); #1;
    start = 1'b0; bcd_in = 8'($urandom);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int waited;
    waited = 0;
    while (cnt_done == d0 && waited < 200) begin @(posedge clk); #1; waited++; end
    check_val({tag, "_done_seen"}, 32'(cnt_done != d0), 32'd1);
  endtask

  task automatic wait_fib(input int f0, input string tag);
    int waited;
    waited = 0;
    while (cnt_fib == f0 && waited < 100) begin @(posedge clk); #1; waited++; end
    check_val({tag, "_fib_seen"}, 32'(cnt_fib != f0), 32'd1);
  endtask

  task automatic run_txn(input logic [7:0] bcd, input bit extra_start);
    int b0, f0, c0, d0, c_start, stages, n, lat;
    logic [15:0] exp_res;
    logic [1:0]  exp_err;
    b0 = cnt_b2b; f0 = cnt_fib; c0 = cnt_bcd; d0 = cnt_done;
    ref_model(bcd, exp_res, exp_err, stages, n);
    pulse_start(bcd, c_start);
    check_val("busy_after_start", 32'(busy), 32'd1);
    check_val("valid_cleared", 32'(result_valid), 32'd0);
    if (extra_start) begin
      wait_fib(f0, "extra");
      start = 1'b1; bcd_in = 8'h03;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(d0, "txn");
    repeat (4) @(posedge clk);
    #1;
    check_val("result_bcd", 32'(result_bcd), 32'(exp_res));
    check_val("err", 32'(err), 32'(exp_err));
    check_val("result_valid_hold", 32'(result_valid), 32'd1);
    check_val("busy_idle", 32'(busy), 32'd0);
    check_val("done_count", 32'(cnt_done - d0), 32'd1);
    check_val("b2b_starts", 32'(cnt_b2b - b0), 32'(stages >= 1 ? 1 : 0));
    check_val("fib_starts", 32'(cnt_fib - f0), 32'(stages == 3 ? 1 : 0));
    check_val("bcd_starts", 32'(cnt_bcd - c0), 32'(stages == 3 ? 1 : 0));
    if (stages == 3) begin
      check_val("fib_n", 32'(cap_fib_n), 32'(n));
      check_val("bcd_bin", 32'(cap_bcd_bin), 32'(fib_of(n)));
    end
    if (zero_wait && !extra_start) begin
      lat = (stages == 0) ? 2 : (stages == 1) ? 3 : 5;
      check_val("latency", 32'(done_cyc - c_start), 32'(lat));
    end
    $display("txn bcd_in=%h result=%h err=%0d (expect %h/%0d)", bcd, result_bcd, err, exp_res, exp_err);
  endtask

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int c_start, f0, d0;
    logic [3:0] hi, lo;
    int r, n;

    #12;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_valid", 32'(result_valid), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_result", 32'(result_bcd), 32'd0);
    check_val("rst_starts", 32'({b2b_start, fib_start, bcd_start}), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    zero_wait = 1'b1;
    run_txn(8'h10, 1'b0);
    run_txn(8'h20, 1'b0);
    run_txn(8'h21, 1'b0);
    run_txn(8'h1A, 1'b0);
    run_txn(8'h00, 1'b0);

    zero_wait = 1'b0; fib_force = 3;
    run_txn(8'h12, 1'b1);
    fib_force = -1;

    // Watchdog: fib_done withheld until long after the stage expires
    fib_hold = 1'b1;
    f0 = cnt_fib; d0 = cnt_done;
    pulse_start(8'h10, c_start);
    wait_done(d0, "timeout");
    check_val("timeout_err", 32'(err), 32'd3);
    check_val("timeout_result", 32'(result_bcd), 32'hEEEE);
    check_val("timeout_valid", 32'(result_valid), 32'd1);
    check_val("timeout_cycles", 32'(done_cyc - fib_cyc), 32'(TO));
    check_val("timeout_fib_starts", 32'(cnt_fib - f0), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check_val("late_done_count", 32'(cnt_done - d0), 32'd1);
    check_val("late_done_busy", 32'(busy), 32'd0);
    check_val("late_done_err", 32'(err), 32'd3);
    $display("txn bcd_in=10 timeout result=%h err=%0d", result_bcd, err);
    fib_hold = 1'b0;

    // Reset mid-FIB
    run_txn(8'h20, 1'b0);
    fib_force = 3;
    f0 = cnt_fib;
    pulse_start(8'h15, c_start);
    wait_fib(f0, "reset");
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_done", 32'(done), 32'd0);
    check_val("mid_rst_valid", 32'(result_valid), 32'd0);
    check_val("mid_rst_err", 32'(err), 32'd0);
    check_val("mid_rst_result", 32'(result_bcd), 32'd0);
    check_val("mid_rst_operands", 32'({b2b_bcd, fib_n, bcd_bin}), 32'd0);
    check_val("mid_rst_starts", 32'({b2b_start, fib_start, bcd_start}), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    d0 = cnt_done;
    repeat (8) @(posedge clk);
    #1;
    check_val("post_rst_no_done", 32'(cnt_done - d0), 32'd0);
    check_val("post_rst_busy", 32'(busy), 32'd0);
    $display("txn bcd_in=15 aborted by reset busy=%0d done_count=%0d", busy, cnt_done - d0);
    fib_force = -1;
    zero_wait = 1'b1;
    run_txn(8'h05, 1'b0);

    for (int t = 0; t < 30; t++) begin
      zero_wait = ($urandom_range(0, 1) == 1);
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        hi = 4'($urandom_range(0, 15));
        lo = 4'($urandom_range(10, 15));
        if (r == 0) run_txn({hi, lo}, 1'b0);
        else        run_txn({lo, hi}, 1'b0);
      end else if (r < 6) begin
        n = int'($urandom_range(0, 20));
        run_txn({4'(n / 10), 4'(n % 10)}, 1'b0);
      end else begin
        hi = 4'($urandom_range(0, 9));
        lo = 4'($urandom_range(0, 9));
        run_txn({hi, lo}, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
